fb_row_reader: RTL and testbench

FB_ROW_READER -- requirements
Module: fb_row_reader

---
 rtl/fb_row_reader_pkg.sv | 15 +
 rtl/fb_skid_fifo.sv | 46 ++++
 rtl/fb_row_reader.sv | 102 ++++++++++
 tb/tb_fb_row_reader.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/fb_row_reader_pkg.sv
// Shared framebuffer geometry and row-reader state encoding.
// Also consumed by the framebuffer write side.
package fb_row_reader_pkg;

  localparam int FB_ADDR_W = 11;
  localparam int FB_DATA_W = 2;
  localparam int FB_COL_W  = 6;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/fb_skid_fifo.sv
// Two-entry output FIFO between framebuffer read data and pixel stream.
// Head entry drives the output directly; occupancy is exported for credit.
module fb_skid_fifo #(
  parameter int DATA_W = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [DATA_W-1:0] din,
  input  logic              pop,
  output logic [DATA_W-1:0] dout,
  output logic              valid,
  output logic [1:0]        count
);

  logic [DATA_W-1:0] mem [2];
  logic              wr;
  logic              rd;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr     <= 1'b0;
      rd     <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr] <= din;
        wr      <= ~wr;
      end
      if (pop) begin
        rd <= ~rd;
      end
      unique case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign dout  = mem[rd];
  assign valid = (count != 2'd0);

endmodule

// File: rtl/fb_row_reader.sv
// Streams one framebuffer row, column 0 upward, through a 2-entry FIFO.
// Fetches are credit-limited so returned read data always has a slot.
module fb_row_reader
  import fb_row_reader_pkg::*;
#(
  parameter int ADDR_W = FB_ADDR_W,
  parameter int DATA_W = FB_DATA_W,
  parameter int COL_W  = FB_COL_W
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [ADDR_W-COL_W-1:0] row_sel,
  output logic                    busy,
  output logic                    row_done,
  output logic [ADDR_W-1:0]       ram_b_address,
  output logic                    ram_b_clk_enable,
  input  logic [DATA_W-1:0]       ram_b_data_out,
  output logic [DATA_W-1:0]       pixel_data,
  output logic                    pixel_valid,
  input  logic                    pixel_ready
);

  localparam int ROW_W = ADDR_W - COL_W;

  state_t            state;
  state_t            nxt;
  logic [ROW_W-1:0]  row_q;
  logic [COL_W-1:0]  col_q;
  logic [ADDR_W-1:0] addr_q;
  logic              inflight_q;
  logic              arm_q;
  logic [1:0]        occ;
  logic [2:0]        pend;
  logic              pop;
  logic              issue;
  logic              accept;
  logic              last;

  assign pop    = pixel_valid & pixel_ready;
  assign pend   = {1'b0, occ} + {2'b0, inflight_q} - {2'b0, pop};
  assign issue  = (state == FETCH) && (pend < 3'd2);
  assign accept = (state == IDLE) && start && arm_q;
  assign last   = &col_q;

  always_comb begin
    nxt      = state;
    row_done = 1'b0;
    unique case (state)
      IDLE:  if (accept) nxt = FETCH;
      FETCH: if (issue && last) nxt = DRAIN;
      DRAIN: begin
        if (occ == 2'd0 && !inflight_q) begin
          nxt      = IDLE;
          row_done = 1'b1;
        end
      end
      default: nxt = IDLE;
    endcase
  end

  // arm_q masks start during the first clock after reset release
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      row_q      <= '0;
      col_q      <= '0;
      addr_q     <= '0;
      inflight_q <= 1'b0;
      arm_q      <= 1'b0;
    end else begin
      state      <= nxt;
      arm_q      <= 1'b1;
      inflight_q <= issue;
      if (accept) begin
        row_q <= row_sel;
        col_q <= '0;
      end else if (issue) begin
        addr_q <= {row_q, col_q};
        if (!last) col_q <= col_q + COL_W'(1);
      end
    end
  end

  assign ram_b_clk_enable = issue;
  assign ram_b_address    = issue ? {row_q, col_q} : addr_q;
  assign busy             = (state != IDLE);

  fb_skid_fifo #(
    .DATA_W(DATA_W)
  ) u_fifo (
    .clk  (clk),
    .reset(reset),
    .push (inflight_q),
    .din  (ram_b_data_out),
    .pop  (pop),
    .dout (pixel_data),
    .valid(pixel_valid),
    .count(occ)
  );

endmodule

// File: tb/tb_fb_row_reader.sv
// Scoreboard bench for fb_row_reader with a 1-cycle-latency RAM model.
// Stimulus queues expected addresses/pixels; a negedge monitor checks them.
module tb_fb_row_reader;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [4:0]  row_sel = '0;
  logic        busy;
  logic        row_done;
  logic [10:0] ram_b_address;
  logic        ram_b_clk_enable;
  logic [1:0]  ram_b_data_out = '0;
  logic [1:0]  pixel_data;
  logic        pixel_valid;
  logic        pixel_ready = 1'b1;

  int nvec = 0;
  int nfail = 0;
  int exp_pix[$];
  int exp_addr[$];
  int exp_done = 0;
  int done_cnt = 0;
  int acc_cnt = 0;
  int outstanding = 0;
  bit rmode = 1'b0;
  bit hold_prev = 1'b0;
  bit last_pop = 1'b0;
  bit pop_m;
  logic [1:0] prev_data = '0;
  logic [15:0] lfsr = 16'hACE1;

  fb_row_reader dut (
    .clk             (clk),
    .reset           (reset),
    .start           (start),
    .row_sel         (row_sel),
    .busy            (busy),
    .row_done        (row_done),
    .ram_b_address   (ram_b_address),
    .ram_b_clk_enable(ram_b_clk_enable),
    .ram_b_data_out  (ram_b_data_out),
    .pixel_data      (pixel_data),
    .pixel_valid     (pixel_valid),
    .pixel_ready     (pixel_ready)
  );

  always #5 clk = ~clk;

  // RAM preloaded with word[a] = a[1:0]
  always @(posedge clk)
    if (ram_b_clk_enable) ram_b_data_out <= ram_b_address[1:0];

  task automatic chk(input string name, input int act, input int exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      lfsr = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      pixel_ready = rmode ? lfsr[0] : 1'b1;
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      outstanding = 0;
      hold_prev   = 1'b0;
      last_pop    = 1'b0;
    end else begin
      pop_m = pixel_valid && pixel_ready;
      if (ram_b_clk_enable) begin
        chk("credit", int'(outstanding - int'(pop_m) < 2), 1);
        if (exp_addr.size() == 0) chk("unexpected_fetch", int'(ram_b_address), -1);
        else chk("address", int'(ram_b_address), exp_addr.pop_front());
      end
      if (hold_prev) begin
        chk("hold_valid", int'(pixel_valid), 1);
        chk("hold_data", int'(pixel_data), int'(prev_data));
      end
      if (pop_m) begin
        acc_cnt++;
        if (exp_pix.size() == 0) chk("unexpected_pixel", int'(pixel_data), -1);
        else chk("pixel", int'(pixel_data), exp_pix.pop_front());
      end
      if (row_done) begin
        done_cnt++;
        chk("done_empty", exp_pix.size(), 0);
        chk("done_timing", int'(last_pop), 1);
      end
      outstanding = outstanding + int'(ram_b_clk_enable) - int'(pop_m);
      hold_prev = pixel_valid && !pixel_ready;
      prev_data = pixel_data;
      last_pop  = pop_m;
    end
  end

  task automatic start_row(input int r, input bit take);
    @(posedge clk);
    #1;
    start   = 1'b1;
    row_sel = 5'(r);
    if (take) begin
      for (int c = 0; c < 64; c++) begin
        exp_pix.push_back(c % 4);
        exp_addr.push_back(r * 64 + c);
      end
      exp_done++;
    end
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done();
    int t = 0;
    while (done_cnt < exp_done && t < 3000) begin
      @(posedge clk);
      t++;
    end
    #1;
    chk("row_done_count", done_cnt, exp_done);
    chk("pix_queue_empty", exp_pix.size(), 0);
    chk("addr_queue_empty", exp_addr.size(), 0);
  endtask

  task automatic chk_reset_outputs();
    chk("rst_busy", int'(busy), 0);
    chk("rst_row_done", int'(row_done), 0);
    chk("rst_valid", int'(pixel_valid), 0);
    chk("rst_data", int'(pixel_data), 0);
    chk("rst_en", int'(ram_b_clk_enable), 0);
    chk("rst_addr", int'(ram_b_address), 0);
  endtask

  initial begin
    int base;
    int t;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs();
    start   = 1'b1;
    row_sel = 5'd3;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("start_at_release", int'(busy), 0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("idle_busy", int'(busy), 0);
      chk("idle_en", int'(ram_b_clk_enable), 0);
    end

    // row 0: latency and full-rate throughput
    start_row(0, 1'b1);
    chk("lat_c0_valid", int'(pixel_valid), 0);
    @(posedge clk);
    #1;
    chk("lat_c1_valid", int'(pixel_valid), 0);
    @(posedge clk);
    #1;
    chk("lat_c2_valid", int'(pixel_valid), 1);
    repeat (64) @(posedge clk);
    #1;
    chk("row_done_at_65", int'(row_done), 1);
    wait_done();
    @(posedge clk);
    #1;
    chk("busy_after_done", int'(busy), 0);

    start_row(31, 1'b1);
    wait_done();
    chk("addr_hold_7ff", int'(ram_b_address), 'h7FF);
    repeat (3) @(posedge clk);
    #1;
    chk("no_second_pass", int'(ram_b_clk_enable), 0);
    chk("addr_still_7ff", int'(ram_b_address), 'h7FF);

    rmode = 1'b1;
    start_row(0, 1'b1);
    wait_done();

    start_row(2, 1'b1);
    repeat (10) @(posedge clk);
    start_row(5, 1'b0);
    wait_done();
    rmode = 1'b0;

    start_row(7, 1'b1);
    base = acc_cnt;
    t = 0;
    while (acc_cnt - base < 20 && t < 500) begin
      @(posedge clk);
      t++;
    end
    chk("reached_pixel_20", int'(acc_cnt - base >= 20), 1);
    #2;
    reset = 1'b0;
    #1;
    chk_reset_outputs();
    exp_pix.delete();
    exp_addr.delete();
    exp_done--;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("post_abort_busy", int'(busy), 0);
    chk("post_abort_valid", int'(pixel_valid), 0);
    start_row(7, 1'b1);
    wait_done();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
